// File: rtl/run_detect_scheduler.sv
// run_detect_scheduler: round-robin time-shared run-of-ones detector with a single-entry match event port
// Ports: clk/rst_n (async active-low) clock and reset; enable freezes arbitration and counters; clear zeroes all state
//   in_valid/in_bit/in_ready per-channel serial bit handshake (in_ready is the one-hot grant)
//   ch_match per-channel run-reached level; evt_valid/evt_ch/evt_ready event port; evt_overflow sticky drop flag
module run_detect_scheduler #(
  parameter int NCH = 4,
  parameter int RUN_LEN = 3,
  localparam int CW = $clog2(RUN_LEN + 1),
  localparam int IW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           clear,
  input  logic [NCH-1:0] in_valid,
  input  logic [NCH-1:0] in_bit,
  output logic [NCH-1:0] in_ready,
  output logic [NCH-1:0] ch_match,
  output logic           evt_valid,
  output logic [IW-1:0]  evt_ch,
  input  logic           evt_ready,
  output logic           evt_overflow
);
  logic [IW-1:0] ptr, ptr_nxt, gnt_idx;
  logic          gnt_any, go, new_evt;
  logic [CW-1:0] cnt [NCH];
  logic [CW-1:0] cnt_nxt [NCH];
  // descending search so the candidate closest to ptr is the last (winning) assignment
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (in_valid[IW'((int'(ptr) + k) % NCH)]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % NCH);
      end
  end
  assign go       = enable && !clear && gnt_any;
  assign in_ready = go ? NCH'(1) << gnt_idx : '0;
  assign ptr_nxt  = (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + IW'(1);
  // an event fires only on the transition into the saturated state
  assign new_evt  = go && in_bit[gnt_idx] && cnt[gnt_idx] == CW'(RUN_LEN - 1);
  always_comb begin
    for (int i = 0; i < NCH; i++)
      cnt_nxt[i] = !in_ready[i] ? cnt[i] :
                   !in_bit[i] ? '0 :
                   (cnt[i] == CW'(RUN_LEN)) ? cnt[i] : cnt[i] + CW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      ch_match     <= '0;
      evt_valid    <= 1'b0;
      evt_ch       <= '0;
      evt_overflow <= 1'b0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else if (clear) begin
      ptr          <= '0;
      ch_match     <= '0;
      evt_valid    <= 1'b0;
      evt_ch       <= '0;
      evt_overflow <= 1'b0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      if (go) ptr <= ptr_nxt;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]      <= cnt_nxt[i];
        ch_match[i] <= cnt_nxt[i] == CW'(RUN_LEN);
      end
      if (new_evt && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_ch    <= gnt_idx;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (new_evt && evt_valid && !evt_ready) evt_overflow <= 1'b1;
    end
  end
endmodule
